micro_sequencer: RTL
====================

Name: micro_sequencer

Overview:
Sequential front end for the combinational instruction decoder. Owns the instruction register, the micro-step counter, the latched ALU flag register and the halt/run state, and feeds o_instruction, o_step and o_zero/o_carry/o_odd straight into the decoder. It consumes the decoder's II, ADV, HLT and EL control bits, closing the fetch/execute loop.

Parameters:
INSTRUCTION_WIDTH, 16, width of the bus word and the instruction register
INSTRUCTION_STEPS, 32, number of micro-steps per instruction; STEP_WIDTH = $clog2(INSTRUCTION_STEPS)
RETIRE_WIDTH, 32, width of the retired-instruction counter

Ports:
i_clk  in  1  system clock, rising edge
i_reset  in  1  asynchronous, active-high reset
i_run  in  1  clock enable; low freezes all state
i_bus  in  INSTRUCTION_WIDTH  data bus, source of the instruction word
i_ir_load  in  1  decoder II bit; load the IR from i_bus
i_adv  in  1  decoder ADV bit; current instruction ends this cycle
i_halt  in  1  decoder HLT bit
i_flags_load  in  1  decoder EL bit; latch the ALU flags
i_alu_zero / i_alu_carry / i_alu_odd  in  1 each  raw ALU flags
o_instruction  out  INSTRUCTION_WIDTH  IR contents, to the decoder
o_step  out  STEP_WIDTH  current micro-step, to the decoder
o_zero / o_carry / o_odd  out  1 each  latched flags, to the decoder
o_halted  out  1  halt state reached
o_step_overflow  out  1  sticky error flag
o_retired  out  RETIRE_WIDTH  count of completed instructions

Behaviour:
- Interface: one clock, i_clk. Reset i_reset is asynchronous and active-high.
- Reset values: IR=0 (NOP), step=0, flags=0, halted=0, overflow=0, retired=0. Reset asserted mid-instruction aborts it; the next step after release is 0 (fetch).
- Update rule: a rising edge is "active" when i_run=1 and halted=0. Otherwise every register holds.
- Step counter, on an active edge (first matching rule wins):
  - i_halt=1: halted<=1, step holds, no other updates.
  - i_adv=1: step<=0, retired<=retired+1 (wraps modulo 2^RETIRE_WIDTH).
  - step==INSTRUCTION_STEPS-1: step<=0, o_step_overflow<=1 (sticky until reset), retired unchanged.
  - otherwise: step<=step+1.
- i_ir_load on an active edge: IR<=i_bus. This is independent of i_adv; if both are high, both apply.
- i_flags_load on an active edge: flags<=ALU flags. This is independent of adv/ir_load. When i_halt=1, the flags are NOT loaded.
- All outputs are registered. The decoder sees new values one cycle after the edge, so latency from control bit to effect is 1 clock.
- Halt is terminal; only reset clears it.
- Fetch sequence from reset: step 0 → 1 (IR loaded) → 2…

Optional Feature:
Macro SEQ_SINGLE_STEP_EN.
- Defined: adds ports i_step_mode (1) and i_step_pulse (1). While i_step_mode=1, an edge is active only if i_step_pulse=1 (one micro-step per pulse). i_step_pulse must be a single-cycle pulse, synchronised by the caller.
- Undefined: these ports do not exist, and behaviour equals i_step_mode=0.

Decomposition:
- Shared package/include (control_words): control-word bit indices for II/ADV/HLT/EL, plus STEP_WIDTH derivation and the reset IR value (NOP=0).
- One natural sub-module, step_counter: the step register with adv/halt/overflow priority logic and the overflow flag. The IR, flags and retire counter stay in the top level.

Test Plan:
- Reset, then i_run=1 with no control bits → o_step counts 0,1,…,31, then wraps to 0; o_step_overflow=1 at the edge leaving 31; o_retired=0.
- Step 1 with i_ir_load=1, i_bus=16'h002a; step 3 with i_adv=1 → next cycle o_instruction=16'h002a, o_step=0, o_retired=1.
- At step 2: i_flags_load=1, i_alu_zero=1, i_alu_carry=0, i_alu_odd=1 → o_zero=1, o_carry=0, o_odd=1 next cycle. A later edge with load=0 and ALU flags changed → outputs unchanged.
- At step 2: i_halt=1 with i_flags_load=1 → o_halted=1, o_step stays 2, flags unchanged. Further edges with any inputs → no change. i_reset pulse → all outputs 0.
- i_run=0 for 5 cycles mid-instruction at step 3 → all outputs frozen at step 3; resumes at step 4 after i_run=1.
- With SEQ_SINGLE_STEP_EN and i_step_mode=1: 10 idle cycles then 2 pulses → o_step advances exactly 0→1→2. Asynchronous reset asserted between clock edges → outputs 0 immediately.

Source files
------------

// File: rtl/micro_sequencer_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : micro_sequencer_pkg
//  Description : Shared definitions for the micro-sequencer (control words).
//                - Bit positions of the decoder control bits that the
//                  sequencer consumes (II, ADV, HLT, EL).
//                - Reset value of the instruction register (NOP).
//                - Helper that derives the step-counter width.
//  Revision    : 1.0 - initial release
// ============================================================================
package micro_sequencer_pkg;

    // Positions of the sequencer-facing bits inside the decoder control word
    localparam int c_cw_ii_bit  = 0;   // instruction-register load
    localparam int c_cw_adv_bit = 1;   // end of current instruction
    localparam int c_cw_hlt_bit = 2;   // halt
    localparam int c_cw_el_bit  = 3;   // latch ALU flags

    // Instruction register comes out of reset holding NOP
    localparam int c_nop_instruction = 0;

    // Width of a counter that indexes INSTRUCTION_STEPS micro-steps; never
    // narrower than one bit so a degenerate configuration still elaborates.
    function automatic int step_width(input int steps);
        return (steps < 2) ? 1 : $clog2(steps);
    endfunction

endpackage
`default_nettype wire

// File: rtl/micro_sequencer_step_counter.sv
`default_nettype none
// ============================================================================
//  Module      : micro_sequencer_step_counter
//  Description : Micro-step register with halt/advance/overflow priority and
//                a sticky overflow flag.
//  Ports       : i_clk       - system clock, rising edge
//                i_reset     - asynchronous active-high reset
//                i_active    - this edge is an active edge
//                i_halt      - decoder HLT bit (step holds)
//                i_adv       - decoder ADV bit (step returns to 0)
//                o_step      - current micro-step
//                o_overflow  - sticky: step ran past the last slot
//                o_retire    - one-cycle strobe, instruction completes
//  Revision    : 1.0 - initial release
// ============================================================================
module micro_sequencer_step_counter
    import micro_sequencer_pkg::*;
#(
    parameter  int INSTRUCTION_STEPS = 32,
    localparam int STEP_WIDTH        = step_width(INSTRUCTION_STEPS)
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic                  i_active,
    input  logic                  i_halt,
    input  logic                  i_adv,
    output logic [STEP_WIDTH-1:0] o_step,
    output logic                  o_overflow,
    output logic                  o_retire
);

    localparam logic [STEP_WIDTH-1:0] c_last_step = STEP_WIDTH'(INSTRUCTION_STEPS - 1);

    logic [STEP_WIDTH-1:0] r_step;
    logic                  r_overflow;
    logic [STEP_WIDTH-1:0] w_step_next;
    logic                  w_overflow_next;

    // Priority: halt freezes, advance restarts, running off the end wraps
    // and records the fault, otherwise count up.
    always_comb begin
        w_step_next     = r_step;
        w_overflow_next = r_overflow;
        if (i_active && !i_halt) begin
            if (i_adv) begin
                w_step_next = '0;
            end else if (r_step == c_last_step) begin
                w_step_next     = '0;
                w_overflow_next = 1'b1;
            end else begin
                w_step_next = r_step + 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_step     <= '0;
            r_overflow <= 1'b0;
        end else begin
            r_step     <= w_step_next;
            r_overflow <= w_overflow_next;
        end
    end

    assign o_step     = r_step;
    assign o_overflow = r_overflow;
    assign o_retire   = i_active & ~i_halt & i_adv;

endmodule
`default_nettype wire

// File: rtl/micro_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : micro_sequencer
//  Description : Sequential front end of the instruction decoder. Holds the
//                instruction register, micro-step counter, latched ALU flags,
//                halt state and retired-instruction counter.
//                Optional feature macro: SEQ_SINGLE_STEP_EN adds
//                i_step_mode/i_step_pulse for one micro-step per pulse.
//  Ports       : i_clk, i_reset (async, active high), i_run (clock enable)
//                i_bus, i_ir_load, i_adv, i_halt, i_flags_load
//                i_alu_zero/i_alu_carry/i_alu_odd  - raw ALU flags
//                o_instruction, o_step, o_zero/o_carry/o_odd - to decoder
//                o_halted, o_step_overflow, o_retired - status
//  Revision    : 1.0 - initial release
// ============================================================================
module micro_sequencer
    import micro_sequencer_pkg::*;
#(
    parameter  int INSTRUCTION_WIDTH = 16,
    parameter  int INSTRUCTION_STEPS = 32,
    parameter  int RETIRE_WIDTH      = 32,
    localparam int STEP_WIDTH        = step_width(INSTRUCTION_STEPS)
) (
    input  logic                         i_clk,
    input  logic                         i_reset,
    input  logic                         i_run,
`ifdef SEQ_SINGLE_STEP_EN
    input  logic                         i_step_mode,
    input  logic                         i_step_pulse,
`endif
    input  logic [INSTRUCTION_WIDTH-1:0] i_bus,
    input  logic                         i_ir_load,
    input  logic                         i_adv,
    input  logic                         i_halt,
    input  logic                         i_flags_load,
    input  logic                         i_alu_zero,
    input  logic                         i_alu_carry,
    input  logic                         i_alu_odd,
    output logic [INSTRUCTION_WIDTH-1:0] o_instruction,
    output logic [STEP_WIDTH-1:0]        o_step,
    output logic                         o_zero,
    output logic                         o_carry,
    output logic                         o_odd,
    output logic                         o_halted,
    output logic                         o_step_overflow,
    output logic [RETIRE_WIDTH-1:0]      o_retired
);

    localparam logic [INSTRUCTION_WIDTH-1:0] c_ir_reset = INSTRUCTION_WIDTH'(c_nop_instruction);

    logic [INSTRUCTION_WIDTH-1:0] r_instruction;
    logic                         r_zero;
    logic                         r_carry;
    logic                         r_odd;
    logic                         r_halted;
    logic [RETIRE_WIDTH-1:0]      r_retired;

    logic w_edge_enable;
    logic w_active;
    logic w_commit;
    logic w_retire;

`ifdef SEQ_SINGLE_STEP_EN
    // In step mode only the caller's pulse lets an edge through.
    assign w_edge_enable = i_run & (~i_step_mode | i_step_pulse);
`else
    assign w_edge_enable = i_run;
`endif

    assign w_active = w_edge_enable & ~r_halted;
    // A halting edge updates nothing but the halt state itself.
    assign w_commit = w_active & ~i_halt;

    micro_sequencer_step_counter #(
        .INSTRUCTION_STEPS (INSTRUCTION_STEPS)
    ) u_step_counter (
        .i_clk      (i_clk),
        .i_reset    (i_reset),
        .i_active   (w_active),
        .i_halt     (i_halt),
        .i_adv      (i_adv),
        .o_step     (o_step),
        .o_overflow (o_step_overflow),
        .o_retire   (w_retire)
    );

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_instruction <= c_ir_reset;
            r_zero        <= 1'b0;
            r_carry       <= 1'b0;
            r_odd         <= 1'b0;
            r_halted      <= 1'b0;
            r_retired     <= '0;
        end else begin
            if (w_active && i_halt) begin
                r_halted <= 1'b1;
            end
            if (w_commit && i_ir_load) begin
                r_instruction <= i_bus;
            end
            if (w_commit && i_flags_load) begin
                r_zero  <= i_alu_zero;
                r_carry <= i_alu_carry;
                r_odd   <= i_alu_odd;
            end
            if (w_retire) begin
                r_retired <= r_retired + 1'b1;
            end
        end
    end

    assign o_instruction = r_instruction;
    assign o_zero        = r_zero;
    assign o_carry       = r_carry;
    assign o_odd         = r_odd;
    assign o_halted      = r_halted;
    assign o_retired     = r_retired;

endmodule
`default_nettype wire
